lu_rr_scheduler: RTL and testbench

//  Time-shares one combinational 2-input logical unit (a, b, func[3:0] -> out) among N_REQ requesters.
//  - Round-robin arbitration picks one requester.
//  - The winner's operands are registered onto the unit's input pins.
//  - The result is captured and returned through a valid/ready response port tagged with the requester id.
//  - Sits between the requester blocks and the single shared logical unit instance.

---
 rtl/lu_rr_scheduler.sv | 125 ++++++++++++
 tb/tb_lu_rr_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lu_rr_scheduler.sv
// rtl/lu_rr_scheduler.sv - round-robin scheduler sharing one combinational logical unit among N_REQ requesters
// Optional feature macro: LU_OPCNT_EN (adds saturating op_count[15:0] of completed responses)
module lu_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     a_bus,
    input  logic [N_REQ-1:0]     b_bus,
    input  logic [4*N_REQ-1:0]   func_bus,
    output logic [N_REQ-1:0]     grant,
    output logic                 lu_a,
    output logic                 lu_b,
    output logic [3:0]           lu_func,
    input  logic                 lu_out,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_data,
    input  logic                 rsp_ready,
`ifdef LU_OPCNT_EN
    output logic [15:0]          op_count,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] next_ptr;
    logic [ID_W-1:0] cand;
    logic            found;
    int              idx;

    // Round-robin search: first active request at or above the pointer, wrapping modulo N_REQ
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx  = (int'(rr_ptr) + i) % N_REQ;
            cand = idx[ID_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        next_ptr = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end

    // Main FSM: arbitrate, issue operands, capture the result, hold the response until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            lu_a      <= 1'b0;
            lu_b      <= 1'b0;
            lu_func   <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        lu_a    <= a_bus[win];
                        lu_b    <= b_bus[win];
                        lu_func <= func_bus[{win, 2'b00} +: 4];
                        grant   <= N_REQ'(1) << win;
                        rsp_id  <= win;
                        rr_ptr  <= next_ptr;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // lu_* have been stable for a full cycle by the next edge
                    grant <= '0;
                    state <= CAPT;
                end
                CAPT: begin
                    rsp_data  <= lu_out;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    grant     <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef LU_OPCNT_EN
    // Count completed response handshakes, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (rsp_valid && rsp_ready && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lu_rr_scheduler.sv
// tb/tb_lu_rr_scheduler.sv - self-checking bench for lu_rr_scheduler with a transaction-level reference model
module tb_lu_rr_scheduler;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   a_bus;
    logic [3:0]   b_bus;
    logic [15:0]  func_bus;
    logic [3:0]   grant;
    logic         lu_a;
    logic         lu_b;
    logic [3:0]   lu_func;
    logic         lu_out;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic         rsp_data;
    logic         rsp_ready;
    logic         busy;
`ifdef LU_OPCNT_EN
    logic [15:0]  op_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int mrr     = 0;
    int mcnt    = 0;

    lu_rr_scheduler #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .func_bus  (func_bus),
        .grant     (grant),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_func   (lu_func),
        .lu_out    (lu_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
`ifdef LU_OPCNT_EN
        .op_count  (op_count),
`endif
        .busy      (busy)
    );

    // the shared logical unit: result is the func bit selected by {a,b}
    assign lu_out = lu_func[{lu_a, lu_b}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic do_op(input int dly, input bit drop);
        int         w;
        logic       ea;
        logic       eb;
        logic [3:0] ef;
        logic       ed;
        w = pick(req, mrr);
        if (w < 0) begin
            tick();
            check("idle_grant", {28'd0, grant}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            return;
        end
        ea = a_bus[w];
        eb = b_bus[w];
        ef = func_bus[4*w +: 4];
        ed = ef[{ea, eb}];
        tick();
        check("grant", {28'd0, grant}, 32'(1 << w));
        check("lu_a", {31'd0, lu_a}, {31'd0, ea});
        check("lu_b", {31'd0, lu_b}, {31'd0, eb});
        check("lu_func", {28'd0, lu_func}, {28'd0, ef});
        check("busy", {31'd0, busy}, 32'd1);
        if (drop) req[w] = 1'b0;
        mrr = (w + 1) % N;
        tick();
        check("grant_pulse", {28'd0, grant}, 32'd0);
        check("early_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_id", {30'd0, rsp_id}, 32'(w));
        check("rsp_data", {31'd0, rsp_data}, {31'd0, ed});
        for (int k = 0; k < dly; k++) begin
            tick();
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_id", {30'd0, rsp_id}, 32'(w));
            check("hold_data", {31'd0, rsp_data}, {31'd0, ed});
            check("hold_no_grant", {28'd0, grant}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done", {31'd0, rsp_valid}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        if (mcnt < 65535) mcnt++;
`ifdef LU_OPCNT_EN
        check("op_count", {16'd0, op_count}, 32'(mcnt));
`endif
    endtask

    task automatic set_op(input int r, input logic a, input logic b, input logic [3:0] f);
        req[r]            = 1'b1;
        a_bus[r]          = a;
        b_bus[r]          = b;
        func_bus[4*r +: 4] = f;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'd0;
        a_bus     = 4'd0;
        b_bus     = 4'd0;
        func_bus  = 16'd0;
        rsp_ready = 1'b0;
        #2;
        check("reset_outs", {19'd0, grant, lu_a, lu_b, lu_func, rsp_valid, rsp_id, rsp_data, busy}, 32'd0);
        tick();
        rst = 1'b0;

        // round robin with all requesters held high
        set_op(0, 1'b1, 1'b1, 4'b0001);
        set_op(1, 1'b1, 1'b1, 4'b0110);
        set_op(2, 1'b1, 1'b1, 4'b1000);
        set_op(3, 1'b1, 1'b1, 4'b1110);
        for (int i = 0; i < 5; i++) do_op(0, 1'b0);
        req = 4'd0;

        // single op through requester 1
        set_op(1, 1'b1, 1'b0, 4'b0100);
        do_op(0, 1'b1);

        // backpressure
        set_op(3, 1'b0, 1'b1, 4'b0010);
        do_op(5, 1'b1);

        // every (a,b) and func combination through requester 2
        for (int ab = 0; ab < 4; ab++) begin
            for (int f = 0; f < 16; f++) begin
                set_op(2, 1'(ab >> 1), 1'(ab & 1), 4'(f));
                do_op(0, 1'b1);
            end
        end

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            for (int r = 0; r < N; r++) begin
                if (!req[r] && ($urandom_range(1, 0) == 1)) begin
                    set_op(r, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
                end
            end
            do_op($urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end
        req = 4'd0;
        tick();

        // reset while a response is pending
        set_op(2, 1'b1, 1'b1, 4'b1000);
        tick();
        req = 4'd0;
        tick();
        tick();
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {19'd0, grant, lu_a, lu_b, lu_func, rsp_valid, rsp_id, rsp_data, busy}, 32'd0);
        tick();
        rst  = 1'b0;
        mrr  = 0;
        mcnt = 0;
        set_op(0, 1'b0, 1'b0, 4'b0001);
        set_op(3, 1'b1, 1'b1, 4'b1000);
        do_op(1, 1'b1);
        do_op(0, 1'b1);

`ifdef LU_OPCNT_EN
        force dut.op_count = 16'hFFFE;
        tick();
        release dut.op_count;
        mcnt = 65534;
        for (int i = 0; i < 3; i++) begin
            set_op(1, 1'b0, 1'b1, 4'b0010);
            do_op(0, 1'b1);
        end
        check("op_count_sat", {16'd0, op_count}, 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
